// File: rtl/uart7n_tx_arbiter.sv
// rtl/uart7n_tx_arbiter.sv - round-robin arbiter sharing one uart tx among byte requesters
// Optional watchdog: define UART7N_TX_ARB_TIMEOUT_EN.
module uart7n_tx_arbiter #(
    parameter int p_num_req        = 4,
    parameter int p_id_w           = 2,
    parameter int p_timeout_cycles = 1_000_000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [p_num_req-1:0]     req_i,
    input  logic [8*p_num_req-1:0]   data_i,
    output logic [p_num_req-1:0]     ack_o,
    output logic                     done_o,
    output logic [p_id_w-1:0]        active_id_o,
    output logic                     busy_o,
    output logic [7:0]               tx_data_o,
    output logic                     tx_enable_o,
    input  logic                     tx_busy_i,
    input  logic                     tx_data_sent_i,
    output logic                     timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_DONE
    } state_t;

    localparam logic [p_id_w:0] c_num = (p_id_w+1)'(p_num_req);

    state_t                 state_q, state_d;
    logic [p_id_w-1:0]      last_q, last_d;
    logic [p_id_w-1:0]      active_id_q, active_id_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic [p_num_req-1:0]   ack_q, ack_d;
    logic                   done_q, done_d;
    logic                   timeout_q, timeout_d;

    logic [2*p_num_req-1:0] req_dbl;
    logic [2*p_num_req-1:0] req_rot;
    logic [p_id_w:0]        win_off;
    logic [p_id_w:0]        win_sum;
    logic [p_id_w-1:0]      win;
    logic                   win_vld;
    logic [7:0]             win_data;

`ifdef UART7N_TX_ARB_TIMEOUT_EN
    localparam int p_cnt_w = $clog2(p_timeout_cycles + 1);
    localparam logic [p_cnt_w-1:0] c_cnt_last = p_cnt_w'(p_timeout_cycles - 1);
    logic [p_cnt_w-1:0]     cnt_q, cnt_d;
`endif

    // Round-robin pick: rotate so the slot after last sits at bit 0, take the lowest set bit.
    always_comb begin
        req_dbl = {req_i, req_i};
        req_rot = req_dbl >> (last_q + 1'b1);
        win_off = '0;
        win_vld = 1'b0;
        for (int j = p_num_req - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                win_off = (p_id_w+1)'(j);
                win_vld = 1'b1;
            end
        end
        win_sum = {1'b0, last_q} + {{p_id_w{1'b0}}, 1'b1} + win_off;
        if (win_sum >= c_num) begin
            win_sum = win_sum - c_num;
        end
        win = win_sum[p_id_w-1:0];
        win_data = '0;
        for (int k = 0; k < p_num_req; k++) begin
            if (win == p_id_w'(k)) begin
                win_data = data_i[8*k +: 8];
            end
        end
    end

    // Next-state: capture in IDLE, hand to uart in START, wait for the frame in WAIT_DONE.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        active_id_d = active_id_q;
        tx_data_d   = tx_data_q;
        ack_d       = '0;
        done_d      = 1'b0;
        timeout_d   = 1'b0;
`ifdef UART7N_TX_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    tx_data_d   = win_data;
                    active_id_d = win;
                    ack_d[win]  = 1'b1;
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                if (tx_busy_i) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_data_sent_i && !tx_busy_i) begin
                    done_d  = 1'b1;
                    last_d  = active_id_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`ifdef UART7N_TX_ARB_TIMEOUT_EN
        // A completed frame wins over a watchdog expiry on the same edge.
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (state_d != ST_IDLE) begin
            if (cnt_q == c_cnt_last) begin
                timeout_d = 1'b1;
                last_d    = active_id_q;
                state_d   = ST_IDLE;
                cnt_d     = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            last_q      <= p_id_w'(p_num_req - 1);
            active_id_q <= '0;
            tx_data_q   <= '0;
            ack_q       <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef UART7N_TX_ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            active_id_q <= active_id_d;
            tx_data_q   <= tx_data_d;
            ack_q       <= ack_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
`ifdef UART7N_TX_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign ack_o       = ack_q;
    assign done_o      = done_q;
    assign active_id_o = active_id_q;
    assign tx_data_o   = tx_data_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign tx_enable_o = (state_q == ST_START);
`ifdef UART7N_TX_ARB_TIMEOUT_EN
    assign timeout_o   = timeout_q;
`else
    assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_uart7n_tx_arbiter.sv
// tb/tb_uart7n_tx_arbiter.sv - self-checking bench for uart7n_tx_arbiter
module tb_uart7n_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;
`ifdef UART7N_TX_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_i;
    logic [N-1:0]  req_i;
    logic [8*N-1:0] data_i;
    logic [N-1:0]  ack_o;
    logic          done_o;
    logic [1:0]    active_id_o;
    logic          busy_o;
    logic [7:0]    tx_data_o;
    logic          tx_enable_o;
    logic          tx_busy_i;
    logic          tx_data_sent_i;
    logic          timeout_o;

    int n_chk = 0;
    int n_err = 0;

    bit uart_on;
    bit uart_rand;
    int busy_dly;
    int sent_dly;

    uart7n_tx_arbiter #(.p_num_req(N), .p_id_w(2), .p_timeout_cycles(TO)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .data_i(data_i),
        .ack_o(ack_o), .done_o(done_o), .active_id_o(active_id_o), .busy_o(busy_o),
        .tx_data_o(tx_data_o), .tx_enable_o(tx_enable_o), .tx_busy_i(tx_busy_i),
        .tx_data_sent_i(tx_data_sent_i), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] req, input int last);
        for (int i = 1; i <= N; i++) begin
            if (req[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    // UART stand-in: busy some cycles after enable, then sent pulse with busy low.
    initial begin
        int ph;
        int cnt;
        ph = 0;
        cnt = 0;
        tx_busy_i = 1'b0;
        tx_data_sent_i = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_i === 1'b1 || !uart_on) begin
                ph = 0;
                tx_busy_i = 1'b0;
                tx_data_sent_i = 1'b0;
            end else begin
                case (ph)
                    0: begin
                        tx_data_sent_i = 1'b0;
                        if (tx_enable_o) begin
                            if (uart_rand) begin
                                busy_dly = $urandom_range(1, 3);
                                sent_dly = $urandom_range(2, 8);
                            end
                            ph = 1;
                            cnt = 1;
                        end
                    end
                    1: begin
                        if (cnt >= busy_dly) begin
                            tx_busy_i = 1'b1;
                            ph = 2;
                            cnt = 0;
                        end else begin
                            cnt++;
                        end
                    end
                    default: begin
                        cnt++;
                        if (cnt >= sent_dly) begin
                            tx_busy_i = 1'b0;
                            tx_data_sent_i = 1'b1;
                            ph = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Reference model: one frame in flight at a time, winner by round-robin from last served.
    initial begin
        bit inflight;
        int m_last, m_cur, m_cnt;
        logic [7:0] m_byte;
        logic [N-1:0] req_s, exp_ack;
        logic [8*N-1:0] data_s;
        logic busy_s, sent_s, rst_s, exp_done, exp_to;
        inflight = 0;
        m_last = N - 1;
        m_cur = 0;
        m_cnt = 0;
        m_byte = 8'h00;
        forever begin
            @(posedge clk);
            req_s = req_i; data_s = data_i; busy_s = tx_busy_i; sent_s = tx_data_sent_i; rst_s = rst_i;
            exp_ack = '0; exp_done = 1'b0; exp_to = 1'b0;
            if (rst_s) begin
                inflight = 0;
                m_last = N - 1;
                m_byte = 8'h00;
                m_cur = 0;
            end else if (inflight) begin
                if (sent_s && !busy_s) begin
                    exp_done = 1'b1;
                    inflight = 0;
                    m_last = m_cur;
                end else if (TO_EN) begin
                    m_cnt++;
                    if (m_cnt == TO) begin
                        exp_to = 1'b1;
                        inflight = 0;
                        m_last = m_cur;
                    end
                end
            end else if (req_s != '0) begin
                m_cur = rr_pick(req_s, m_last);
                m_byte = data_s[8*m_cur +: 8];
                exp_ack = N'(1) << m_cur;
                inflight = 1;
                m_cnt = 0;
            end
            #1;
            if (rst_s !== 1'b1 && rst_s !== 1'b0) continue;
            check("mdl_ack", ack_o, exp_ack);
            check("mdl_done", done_o, exp_done);
            check("mdl_timeout", timeout_o, exp_to);
            check("mdl_busy", busy_o, inflight);
            if (inflight || exp_done) check("mdl_tx_data", tx_data_o, m_byte);
            if (inflight) check("mdl_active_id", active_id_o, m_cur);
        end
    end

    task automatic wait_ack(output int waited);
        waited = 0;
        while (ack_o == '0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (ack_o == '0) check("ack_wait_expired", 0, 1);
    endtask

    task automatic wait_done();
        int w;
        w = 0;
        while (done_o !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("done_seen", done_o, 1);
    endtask

    typedef struct {
        logic [N-1:0]   req;
        logic [8*N-1:0] data;
        int             exp_id;
        logic [7:0]     exp_byte;
    } vec_t;

    initial begin
        vec_t tbl[8];
        int waited;
        logic [7:0] held_exp[5];

        tbl[0] = '{4'b0001, 32'h0000_0055, 0, 8'h55};
        tbl[1] = '{4'b0100, 32'h00C2_0000, 2, 8'hC2};
        tbl[2] = '{4'b0101, 32'h00C2_00B0, 0, 8'hB0};
        tbl[3] = '{4'b0101, 32'h00D2_00D0, 2, 8'hD2};
        tbl[4] = '{4'b1010, 32'hE300_E100, 3, 8'hE3};
        tbl[5] = '{4'b1111, 32'hF3F2_F1F0, 0, 8'hF0};
        tbl[6] = '{4'b1110, 32'h1312_1110, 1, 8'h11};
        tbl[7] = '{4'b1001, 32'h2300_0020, 3, 8'h23};
        held_exp[0] = 8'hA0; held_exp[1] = 8'hA1; held_exp[2] = 8'hA2;
        held_exp[3] = 8'hA3; held_exp[4] = 8'hA0;

        rst_i = 1'b1; req_i = '0; data_i = '0;
        uart_on = 1'b1; uart_rand = 1'b0;
        busy_dly = 3; sent_dly = TO_EN ? 8 : 20;
        repeat (3) @(negedge clk);
        check("rst_ack", ack_o, 0);
        check("rst_done", done_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_tx_enable", tx_enable_o, 0);
        check("rst_tx_data", tx_data_o, 0);
        check("rst_active_id", active_id_o, 0);
        check("rst_timeout", timeout_o, 0);
        rst_i = 1'b0;
        @(negedge clk);

        // Table: one request pattern per row, dropped at ack.
        for (int r = 0; r < 8; r++) begin
            req_i = tbl[r].req;
            data_i = tbl[r].data;
            wait_ack(waited);
            check("tbl_ack_latency", waited, 1);
            check("tbl_ack_onehot", ack_o, N'(1) << tbl[r].exp_id);
            check("tbl_id", active_id_o, tbl[r].exp_id);
            check("tbl_byte", tx_data_o, tbl[r].exp_byte);
            check("tbl_tx_enable", tx_enable_o, 1);
            req_i = '0;
            wait_done();
            check("tbl_busy_after_done", busy_o, 0);
        end

        // All four held: fair rotation 0,1,2,3,0.
        req_i = 4'b1111;
        data_i = 32'hA3A2_A1A0;
        for (int g = 0; g < 5; g++) begin
            if (g > 0) @(negedge clk);
            wait_ack(waited);
            check("held_id", active_id_o, g % 4);
            check("held_byte", tx_data_o, held_exp[g]);
            if (g == 4) req_i = '0;
        end
        wait_done();

        // Data changed after capture must not affect the frame in flight.
        req_i = 4'b0010;
        data_i = 32'h0000_1100;
        wait_ack(waited);
        check("chg_id", active_id_o, 1);
        req_i = '0;
        waited = 0;
        while (!tx_busy_i && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("chg_uart_busy", tx_busy_i, 1);
        data_i = 32'h0000_2200;
        wait_done();
        check("chg_tx_data_at_done", tx_data_o, 8'h11);

        // Reset in WAIT_DONE aborts and restores requester 0 priority.
        @(negedge clk);
        req_i = 4'b1000;
        data_i = 32'h3300_0000;
        wait_ack(waited);
        check("rstmid_id", active_id_o, 3);
        req_i = '0;
        waited = 0;
        while (!tx_busy_i && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        check("rstmid_busy", busy_o, 0);
        check("rstmid_tx_enable", tx_enable_o, 0);
        check("rstmid_done", done_o, 0);
        @(negedge clk);
        rst_i = 1'b0;
        req_i = 4'b1001;
        data_i = 32'h4400_0040;
        wait_ack(waited);
        check("rstmid_next_id", active_id_o, 0);
        check("rstmid_next_byte", tx_data_o, 8'h40);
        req_i = '0;
        wait_done();

`ifdef UART7N_TX_ARB_TIMEOUT_EN
        // Silent UART: watchdog fires TO cycles after START entry, then next pending is served.
        @(negedge clk);
        uart_on = 1'b0;
        req_i = 4'b0011;
        data_i = 32'h0000_5150;
        wait_ack(waited);
        check("to_id", active_id_o, 1);
        req_i = 4'b0001;
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk);
            if (i == TO - 1) check("to_early", timeout_o, 0);
            if (i == TO) begin
                check("to_pulse", timeout_o, 1);
                check("to_no_done", done_o, 0);
            end
        end
        uart_on = 1'b1;
        @(negedge clk);
        wait_ack(waited);
        check("to_next_id", active_id_o, 0);
        req_i = '0;
        wait_done();
`endif

        // Random traffic against the reference model.
        uart_rand = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (req_i[k] && ack_o[k]) begin
                    if ($urandom_range(0, 2) == 0) data_i[8*k +: 8] = 8'($urandom);
                    else req_i[k] = 1'b0;
                end else if (!req_i[k] && $urandom_range(0, 7) == 0) begin
                    data_i[8*k +: 8] = 8'($urandom);
                    req_i[k] = 1'b1;
                end
            end
        end
        @(negedge clk);
        req_i = '0;
        repeat (60) @(negedge clk);
        check("final_idle", busy_o, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
